// File: rtl/control_merge_dataless_if.sv
// control_merge_dataless_if
//   Handshake bundle for the dataless control merge.
//   slave  : view used by control_merge_dataless (consumes ins_valid and the
//            two consumer readies, drives everything else)
//   master : view used by the surrounding network / environment
// Signals
//   ins_valid   [SIZE]         per-input token valid
//   ins_ready   [SIZE]         per-input ready, at most one bit high
//   outs_valid / outs_ready    dataless control token handshake
//   index       [INDEX_WIDTH]  source input of the current token
//   index_valid / index_ready  index handshake
interface control_merge_dataless_if #(
  parameter int SIZE        = 2,
  parameter int INDEX_WIDTH = 1
);
  logic [SIZE-1:0]        ins_valid;
  logic [SIZE-1:0]        ins_ready;
  logic                   outs_valid;
  logic                   outs_ready;
  logic [INDEX_WIDTH-1:0] index;
  logic                   index_valid;
  logic                   index_ready;

  modport slave (
    input  ins_valid, outs_ready, index_ready,
    output ins_ready, outs_valid, index, index_valid
  );

  modport master (
    output ins_valid, outs_ready, index_ready,
    input  ins_ready, outs_valid, index, index_valid
  );
endinterface

// File: rtl/control_merge_dataless.sv
// control_merge_dataless
//   Dataless control merge: arbitrates among SIZE token inputs, passes the
//   winner's index through a one-slot transparent buffer, then eagerly forks
//   the token into a dataless control output and an index output.
//   Zero latency when both consumers are ready; one token per cycle.
// Ports
//   clk  clock, rising edge
//   rst  asynchronous, active-high reset
//   cm   control_merge_dataless_if.slave handshake bundle
// Build option
//   CMERGE_DATALESS_RR_ARB_EN : round-robin arbitration (pointer register
//   last_q). Undefined: fixed lowest-index priority, no pointer.
//
// Buffer state
//   state     | meaning
//   BUF_EMPTY | buffer transparent, grant flows straight to the fork
//   BUF_FULL  | index held in held_q until the fork completes
module control_merge_dataless #(
  parameter int SIZE        = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  control_merge_dataless_if.slave   cm
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] held_q, held_d;
  logic [1:0]             sent_q, sent_d;

  logic                   any;
  logic [INDEX_WIDTH-1:0] grant;
  logic                   full;
  logic                   buf_ready;
  logic                   buf_valid;
  logic [INDEX_WIDTH-1:0] buf_data;
  logic [SIZE-1:0]        ins_ready;
  logic                   outs_valid;
  logic                   index_valid;
  logic [1:0]             done;
  logic                   fork_ready;

`ifdef CMERGE_DATALESS_RR_ARB_EN
  logic [INDEX_WIDTH-1:0] last_q, last_d;
  int                     rr_idx;

  // Scan offsets from far to near so the nearest valid input after last_q
  // is the one left in grant.
  always_comb begin
    grant  = '0;
    rr_idx = 0;
    for (int k = SIZE; k >= 1; k--) begin
      rr_idx = (int'(last_q) + k) % SIZE;
      if (cm.ins_valid[rr_idx]) grant = INDEX_WIDTH'(rr_idx);
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (cm.ins_valid[i]) grant = INDEX_WIDTH'(i);
    end
  end
`endif

  always_comb begin
    any        = |cm.ins_valid;
    full       = (state_q == BUF_FULL);
    buf_ready  = ~full;
    buf_valid  = full | any;
    buf_data   = full ? held_q : grant;

    ins_ready  = '0;
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = any & buf_ready & (grant == INDEX_WIDTH'(i));
    end

    outs_valid  = buf_valid & ~sent_q[0];
    index_valid = buf_valid & ~sent_q[1];

    done[0]    = sent_q[0] | (outs_valid  & cm.outs_ready);
    done[1]    = sent_q[1] | (index_valid & cm.index_ready);
    fork_ready = done[0] & done[1];

    // Token survives the edge only if some side has not handshaked yet.
    state_d = BUF_EMPTY;
    sent_d  = '0;
    if (buf_valid & ~fork_ready) begin
      state_d = BUF_FULL;
      sent_d  = done;
    end

    held_d = held_q;
    if (~full & any & ~fork_ready) held_d = grant;
  end

`ifdef CMERGE_DATALESS_RR_ARB_EN
  always_comb begin
    last_d = last_q;
    if (|(cm.ins_valid & ins_ready)) last_d = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= INDEX_WIDTH'(SIZE - 1);
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      held_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      sent_q  <= sent_d;
    end
  end

  assign cm.ins_ready   = ins_ready;
  assign cm.outs_valid  = outs_valid;
  assign cm.index_valid = index_valid;
  assign cm.index       = buf_data;

endmodule

// File: tb/tb_control_merge_dataless.sv
module tb_control_merge_dataless;

`ifdef CMERGE_DATALESS_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_merge_dataless_if #(.SIZE(2), .INDEX_WIDTH(1)) b2();
  control_merge_dataless_if #(.SIZE(4), .INDEX_WIDTH(2)) b4();

  control_merge_dataless #(.SIZE(2), .INDEX_WIDTH(1)) dut2 (.clk(clk), .rst(rst), .cm(b2.slave));
  control_merge_dataless #(.SIZE(4), .INDEX_WIDTH(2)) dut4 (.clk(clk), .rst(rst), .cm(b4.slave));

  int         sel;
  logic [3:0] iv;
  logic       ordy, irdy;

  assign b2.ins_valid   = (sel == 2) ? iv[1:0] : 2'b00;
  assign b2.outs_ready  = ordy;
  assign b2.index_ready = irdy;
  assign b4.ins_valid   = (sel == 4) ? iv : 4'b0000;
  assign b4.outs_ready  = ordy;
  assign b4.index_ready = irdy;

  int total = 0;
  int bad   = 0;

  // protocol-level model of the selected DUT
  bit   have_tok, out_done, idx_done;
  int   tok_idx, last, n;
  int   q_idx[$];
  int   q_out[$];
  int   in_cnt, o_cnt, i_cnt;
  logic [3:0] o_ir, acc_mask;
  logic       o_ov, o_iv;
  logic [1:0] o_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int nn, input int lst);
    if (RR) begin
      for (int k = 1; k <= nn; k++) begin
        if (v[(lst + k) % nn]) return (lst + k) % nn;
      end
    end else begin
      for (int j = 0; j < nn; j++) begin
        if (v[j]) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_reset(input int nn);
    n = nn; have_tok = 0; out_done = 0; idx_done = 0; tok_idx = 0;
    last = nn - 1; in_cnt = 0; o_cnt = 0; i_cnt = 0; acc_mask = '0;
    q_idx.delete(); q_out.delete();
  endtask

  task automatic sample();
    if (sel == 2) begin
      o_ir = {2'b00, b2.ins_ready}; o_ov = b2.outs_valid;
      o_iv = b2.index_valid;        o_idx = {1'b0, b2.index};
    end else begin
      o_ir = b4.ins_ready; o_ov = b4.outs_valid;
      o_iv = b4.index_valid; o_idx = b4.index;
    end
  endtask

  // one clock cycle: inputs already driven; check, update model, go to next negedge
  task automatic cyc();
    logic [3:0] v, exp_ir;
    bit any, cur_valid, ov_e, iv_e, od, id;
    int p, cur_idx;
    #1;
    sample();
    v   = (n == 2) ? (iv & 4'b0011) : iv;
    any = |v;
    p   = pick(v, n, last);
    cur_valid = have_tok | any;
    cur_idx   = have_tok ? tok_idx : p;
    exp_ir    = (!have_tok && any) ? (4'b0001 << p) : 4'b0000;
    ov_e = cur_valid & ~out_done;
    iv_e = cur_valid & ~idx_done;
    chk("ins_ready", 32'(o_ir), 32'(exp_ir));
    chk("outs_valid", 32'(o_ov), 32'(ov_e));
    chk("index_valid", 32'(o_iv), 32'(iv_e));
    chk("index", 32'(o_idx), cur_valid ? cur_idx : 0);

    acc_mask = exp_ir & v;
    if ((o_ir & v) != 4'b0000) begin
      in_cnt++;
      q_idx.push_back(p);
      q_out.push_back(p);
    end
    if (o_iv && irdy) begin
      i_cnt++;
      if (q_idx.size() == 0) chk("sb_index_empty", 32'(1), 32'(0));
      else chk("sb_index", 32'(o_idx), q_idx.pop_front());
    end
    if (o_ov && ordy) begin
      o_cnt++;
      if (q_out.size() == 0) chk("sb_outs_empty", 32'(1), 32'(0));
      else void'(q_out.pop_front());
    end

    if (!have_tok && any) last = p;
    od = out_done | (ov_e & ordy);
    id = idx_done | (iv_e & irdy);
    if (cur_valid && !(od && id)) begin
      have_tok = 1; tok_idx = cur_idx; out_done = od; idx_done = id;
    end else begin
      have_tok = 0; out_done = 0; idx_done = 0;
    end
    @(negedge clk);
  endtask

  int exp_cont[4];
  logic [3:0] st_ir[4];
  logic       st_ov[4];

  initial begin
    rst = 1'b1; sel = 2; iv = '0; ordy = 1'b0; irdy = 1'b0;
    if (RR) exp_cont = '{0, 1, 0, 1};
    else    exp_cont = '{0, 0, 0, 0};
    st_ir = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
    st_ov = '{1'b1, 1'b0, 1'b0, 1'b0};
    model_reset(2);

    // reset state
    @(negedge clk);
    chk("rst_outs_valid2", 32'(b2.outs_valid), 32'(0));
    chk("rst_index_valid2", 32'(b2.index_valid), 32'(0));
    chk("rst_index2", 32'(b2.index), 32'(0));
    chk("rst_ins_ready2", 32'(b2.ins_ready), 32'(0));
    chk("rst_outs_valid4", 32'(b4.outs_valid), 32'(0));
    chk("rst_ins_ready4", 32'(b4.ins_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // contention
    iv = 4'b0011; ordy = 1'b1; irdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("contention_index", 32'(o_idx), exp_cont[c]);
    end

    // single input, full throughput
    iv = 4'b0001;
    for (int c = 0; c < 10; c++) cyc();
    chk("single_in_cnt", in_cnt, 14);
    chk("single_out_cnt", o_cnt, 14);

    // split stall on the index side, token from input 1
    iv = 4'b0010; ordy = 1'b1; irdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) irdy = 1'b1;
      cyc();
      chk("split_ins_ready", 32'(o_ir), 32'(st_ir[c]));
      chk("split_outs_valid", 32'(o_ov), 32'(st_ov[c]));
      chk("split_index_valid", 32'(o_iv), 32'(1));
      chk("split_index", 32'(o_idx), 32'(1));
    end
    iv = 4'b0000;
    cyc();
    chk("split_hs_balance", o_cnt, i_cnt);

    // reset while full with the outs side already sent
    iv = 4'b0001; ordy = 1'b1; irdy = 1'b0;
    cyc();
    rst = 1'b1; iv = 4'b0000;
    #1;
    chk("midrst_outs_valid", 32'(b2.outs_valid), 32'(0));
    chk("midrst_index_valid", 32'(b2.index_valid), 32'(0));
    chk("midrst_index", 32'(b2.index), 32'(0));
    model_reset(2);
    @(negedge clk);
    rst = 1'b0;
    iv = 4'b0001; irdy = 1'b1;
    for (int c = 0; c < 10; c++) cyc();
    chk("post_rst_in_cnt", in_cnt, 10);

    // SIZE=4 random token conservation
    iv = 4'b0000; cyc();
    sel = 4;
    model_reset(4);
    for (int c = 0; c < 10000; c++) begin
      ordy = ($urandom_range(0, 3) != 0);
      irdy = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) begin
        if (acc_mask[j])  iv[j] = 1'($urandom_range(0, 1));
        else if (!iv[j])  iv[j] = ($urandom_range(0, 2) == 0);
      end
      cyc();
    end
    iv = 4'b0000; ordy = 1'b1; irdy = 1'b1;
    repeat (3) cyc();
    chk("cons_out_cnt", o_cnt, in_cnt);
    chk("cons_idx_cnt", i_cnt, in_cnt);
    chk("cons_idx_queue", q_idx.size(), 0);
    chk("cons_out_queue", q_out.size(), 0);
    chk("cons_activity", 32'(in_cnt > 1000), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
